// File: rtl/fp_add_align.sv
// fp_add_align: alignment stage of the FP32 adder, feeding the 27-bit ripple adder.
// Stage 1 unpacks both operands and orders them by magnitude. Stage 2 right-shifts the
// smaller mantissa into hidden|man|G|R|S form with sticky, then pre-inverts it for
// effective subtraction. Both stages use valid/ready flow control.
// Build option: FP_ALIGN_DENORM_EN keeps subnormal mantissas, using an effective
// exponent of 1. Without it, subnormal operands are flushed to signed zero.
module fp_add_align #(
    parameter int EXP_W = 32'sd8,
    parameter int MAN_W = 32'sd23,
    parameter int WIDTH = 32'sd27
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH:1]         add_a,
    output logic [WIDTH:1]         add_b,
    output logic                   add_cin,
    output logic [EXP_W-1:0]       res_exp,
    output logic                   res_sign,
    output logic                   eff_sub,
    output logic                   out_exc
);

    localparam logic [EXP_W-1:0] WIDTH_E = EXP_W'(WIDTH);

    // stage 1 combinational
    logic                 sign_a_s, sign_b_s, hid_a_s, hid_b_s;
    logic [EXP_W-1:0]     exp_a_s, exp_b_s;
    logic [MAN_W-1:0]     man_a_s, man_b_s;
    logic                 a_is_l_s, eq_mag_s, exc_s;
    logic                 sign_l_s, hid_l_s, hid_sm_s;
    logic [EXP_W-1:0]     exp_l_s, d_s;
    logic [MAN_W-1:0]     man_l_s, man_sm_s;

    // stage 1 registers
    logic                 v1_r, eff_sub1_r, sign_l_r, hid_l_r, hid_sm_r, exc1_r, eq_mag_r;
    logic [EXP_W-1:0]     exp_l_r, d_r;
    logic [MAN_W-1:0]     man_l_r, man_sm_r;

    // stage 2 combinational
    logic [WIDTH:1]       m_full_s, aligned_s, add_a_s, add_b_s;
    logic                 sticky_s, cin_s, res_sign_s;

    // stage 2 (output) registers
    logic                 v2_r, cin_r, res_sign_r, eff_sub_r, exc_r;
    logic [WIDTH:1]       add_a_r, add_b_r;
    logic [EXP_W-1:0]     res_exp_r;

    logic                 s1_load_s, s2_load_s;

    assign s2_load_s = !v2_r || out_ready;
    assign s1_load_s = !v1_r || s2_load_s;
    assign in_ready  = !rst && s1_load_s;

    // Unpack both operands; a zero exponent means subnormal or zero.
    always_comb begin
        sign_a_s = op_a[EXP_W+MAN_W];
        sign_b_s = op_b[EXP_W+MAN_W] ^ sub;
        hid_a_s  = |op_a[EXP_W+MAN_W-1:MAN_W];
        hid_b_s  = |op_b[EXP_W+MAN_W-1:MAN_W];
        exc_s    = (&op_a[EXP_W+MAN_W-1:MAN_W]) || (&op_b[EXP_W+MAN_W-1:MAN_W]);
`ifdef FP_ALIGN_DENORM_EN
        exp_a_s  = hid_a_s ? op_a[EXP_W+MAN_W-1:MAN_W] : {{(EXP_W-1){1'b0}}, 1'b1};
        exp_b_s  = hid_b_s ? op_b[EXP_W+MAN_W-1:MAN_W] : {{(EXP_W-1){1'b0}}, 1'b1};
        man_a_s  = op_a[MAN_W-1:0];
        man_b_s  = op_b[MAN_W-1:0];
`else
        exp_a_s  = op_a[EXP_W+MAN_W-1:MAN_W];
        exp_b_s  = op_b[EXP_W+MAN_W-1:MAN_W];
        man_a_s  = hid_a_s ? op_a[MAN_W-1:0] : {MAN_W{1'b0}};
        man_b_s  = hid_b_s ? op_b[MAN_W-1:0] : {MAN_W{1'b0}};
`endif
    end

    // Order by magnitude; the hidden bit makes a subnormal compare below exponent-1 normals.
    always_comb begin
        a_is_l_s = {exp_a_s, hid_a_s, man_a_s} >= {exp_b_s, hid_b_s, man_b_s};
        eq_mag_s = {exp_a_s, hid_a_s, man_a_s} == {exp_b_s, hid_b_s, man_b_s};
        if (a_is_l_s) begin
            sign_l_s = sign_a_s;  exp_l_s = exp_a_s;  hid_l_s = hid_a_s;  man_l_s = man_a_s;
            hid_sm_s = hid_b_s;   man_sm_s = man_b_s; d_s = exp_a_s - exp_b_s;
        end else begin
            sign_l_s = sign_b_s;  exp_l_s = exp_b_s;  hid_l_s = hid_b_s;  man_l_s = man_b_s;
            hid_sm_s = hid_a_s;   man_sm_s = man_a_s; d_s = exp_b_s - exp_a_s;
        end
    end

    // Stage 1 register: captures the ordered operands when the stage advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;  eff_sub1_r <= 1'b0;  sign_l_r <= 1'b0;  hid_l_r <= 1'b0;
            hid_sm_r <= 1'b0;  exc1_r <= 1'b0;  eq_mag_r <= 1'b0;
            exp_l_r <= {EXP_W{1'b0}};  d_r <= {EXP_W{1'b0}};
            man_l_r <= {MAN_W{1'b0}};  man_sm_r <= {MAN_W{1'b0}};
        end else if (s1_load_s) begin
            v1_r       <= in_valid;
            eff_sub1_r <= sign_a_s ^ sign_b_s;
            sign_l_r   <= sign_l_s;
            hid_l_r    <= hid_l_s;
            hid_sm_r   <= hid_sm_s;
            exc1_r     <= exc_s;
            eq_mag_r   <= eq_mag_s;
            exp_l_r    <= exp_l_s;
            d_r        <= d_s;
            man_l_r    <= man_l_s;
            man_sm_r   <= man_sm_s;
        end else begin
            v1_r <= v1_r;
        end
    end

    // Align the smaller mantissa, fold shifted-out bits into sticky, invert for subtraction.
    always_comb begin
        m_full_s = {hid_sm_r, man_sm_r, 3'b000};
        if (d_r >= WIDTH_E) begin
            sticky_s  = |{hid_sm_r, man_sm_r};
            aligned_s = {{(WIDTH-1){1'b0}}, sticky_s};
        end else begin
            sticky_s  = |(m_full_s & ~({WIDTH{1'b1}} << d_r));
            aligned_s = (m_full_s >> d_r) | {{(WIDTH-1){1'b0}}, sticky_s};
        end
        res_sign_s = (eff_sub1_r && eq_mag_r) ? 1'b0 : sign_l_r;
        if (exc1_r) begin
            add_a_s = {WIDTH{1'b0}};
            add_b_s = {WIDTH{1'b0}};
            cin_s   = 1'b0;
        end else begin
            add_a_s = {hid_l_r, man_l_r, 3'b000};
            add_b_s = eff_sub1_r ? ~aligned_s : aligned_s;
            cin_s   = eff_sub1_r;
        end
    end

    // Stage 2 register: output data held stable while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r <= 1'b0;  cin_r <= 1'b0;  res_sign_r <= 1'b0;  eff_sub_r <= 1'b0;  exc_r <= 1'b0;
            add_a_r <= {WIDTH{1'b0}};  add_b_r <= {WIDTH{1'b0}};  res_exp_r <= {EXP_W{1'b0}};
        end else if (s2_load_s) begin
            v2_r       <= v1_r;
            cin_r      <= cin_s;
            res_sign_r <= res_sign_s;
            eff_sub_r  <= eff_sub1_r;
            exc_r      <= exc1_r;
            add_a_r    <= add_a_s;
            add_b_r    <= add_b_s;
            res_exp_r  <= exp_l_r;
        end else begin
            v2_r <= v2_r;
        end
    end

    assign out_valid = v2_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = cin_r;
    assign res_exp   = res_exp_r;
    assign res_sign  = res_sign_r;
    assign eff_sub   = eff_sub_r;
    assign out_exc   = exc_r;

endmodule
